// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out path: default 1280x1024@60 timing,
// FIFO word packing (four 32-bit pixel lanes per word) and RGB field layout.
package vga_pkg;
   localparam int DEF_IMAGE_WIDTH  = 1280;
   localparam int DEF_IMAGE_HEIGHT = 1024;
   localparam int DEF_H_FRONT      = 48;
   localparam int DEF_H_SYNC       = 112;
   localparam int DEF_H_BACK       = 248;
   localparam int DEF_V_FRONT      = 1;
   localparam int DEF_V_SYNC       = 3;
   localparam int DEF_V_BACK       = 38;

   localparam int LANE_W = 32;
   localparam int LANES  = 4;
   localparam int WORD_W = LANE_W * LANES;

   localparam int RGB_W = 24;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic origin;
   } vga_timing_t;
endpackage

// File: rtl/vga_pixel_out_if.sv
// Show-ahead FIFO read port between the CDC FIFO (master) and the scan-out
// engine (slave).
interface vga_pixel_out_if;
   import vga_pkg::*;

   logic              data_fifo_empty;
   logic [WORD_W-1:0] data_fifo_rd_data;
   logic              vga_rd_valid;

   modport master (
      output data_fifo_empty,
      output data_fifo_rd_data,
      input  vga_rd_valid
   );

   modport slave (
      input  data_fifo_empty,
      input  data_fifo_rd_data,
      output vga_rd_valid
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational active/sync/origin decode; the lane
// index is the low two bits of the horizontal counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int H_FRONT      = DEF_H_FRONT,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BACK       = DEF_H_BACK,
   parameter int V_FRONT      = DEF_V_FRONT,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BACK       = DEF_V_BACK
) (
   input  logic        vga_clk,
   input  logic        vga_reset,
   output vga_timing_t o_tim,
   output logic [1:0]  o_lane
);
   localparam int H_TOTAL = IMAGE_WIDTH + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = IMAGE_HEIGHT + V_FRONT + V_SYNC + V_BACK;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int HS_BEG  = IMAGE_WIDTH + H_FRONT;
   localparam int HS_END  = IMAGE_WIDTH + H_FRONT + H_SYNC;
   localparam int VS_BEG  = IMAGE_HEIGHT + V_FRONT;
   localparam int VS_END  = IMAGE_HEIGHT + V_FRONT + V_SYNC;

   logic [H_W-1:0] r_h_cnt;
   logic [V_W-1:0] r_v_cnt;
   int             w_h;
   int             w_v;

   always_ff @(posedge vga_clk) begin
      if (vga_reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_W'(H_TOTAL - 1)) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   // Decode in 32-bit space so sync end points equal to the total still compare correctly.
   always_comb begin
      w_h          = int'(r_h_cnt);
      w_v          = int'(r_v_cnt);
      o_tim.active = (w_h < IMAGE_WIDTH) && (w_v < IMAGE_HEIGHT);
      o_tim.hsync  = (w_h >= HS_BEG) && (w_h < HS_END);
      o_tim.vsync  = (w_v >= VS_BEG) && (w_v < VS_END);
      o_tim.origin = (w_h == 0) && (w_v == 0);
      o_lane       = r_h_cnt[1:0];
   end
endmodule

// File: rtl/vga_pixel_out.sv
// VGA scan-out: pops 128-bit FIFO words, unpacks four pixels per word, and
// tracks missed words as debt that is drained during blanking.
module vga_pixel_out
   import vga_pkg::*;
#(
   parameter int               IMAGE_WIDTH   = DEF_IMAGE_WIDTH,
   parameter int               IMAGE_HEIGHT  = DEF_IMAGE_HEIGHT,
   parameter int               H_FRONT       = DEF_H_FRONT,
   parameter int               H_SYNC        = DEF_H_SYNC,
   parameter int               H_BACK        = DEF_H_BACK,
   parameter int               V_FRONT       = DEF_V_FRONT,
   parameter int               V_SYNC        = DEF_V_SYNC,
   parameter int               V_BACK        = DEF_V_BACK,
   parameter bit               SYNC_POL      = 1'b1,
   parameter logic [RGB_W-1:0] UNDERFLOW_RGB = 24'hFF00FF
) (
   input  logic                   vga_clk,
   input  logic                   vga_reset,
   input  logic                   enable,
   vga_pixel_out_if.slave         fifo,
   output logic                   vga_hsync,
   output logic                   vga_vsync,
   output logic                   vga_de,
   output logic [7:0]             vga_r,
   output logic [7:0]             vga_g,
   output logic [7:0]             vga_b,
   output logic                   frame_start,
   output logic                   underflow,
   input  logic                   underflow_clr
);
   localparam int DEBT_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT / LANES + 1);

   vga_timing_t                  w_tim;
   logic [1:0]                   w_lane;
   logic                         w_run;
   logic                         w_grab;
   logic                         w_miss;
   logic                         w_drain;
   logic [RGB_W-1:0]             w_pix;
   logic                         w_unused_alpha;

   logic                         r_run;
   logic [DEBT_W-1:0]            r_debt;
   logic                         r_word_ok;
   logic [LANES-1:1][RGB_W-1:0]  r_pix;

   logic                         r_hsync_p1;
   logic                         r_vsync_p1;
   logic                         r_de_p1;
   logic [RGB_W-1:0]             r_rgb_p1;
   logic                         r_fs_p1;
   logic                         r_underflow;

   vga_timing_gen #(
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .IMAGE_HEIGHT (IMAGE_HEIGHT),
      .H_FRONT      (H_FRONT),
      .H_SYNC       (H_SYNC),
      .H_BACK       (H_BACK),
      .V_FRONT      (V_FRONT),
      .V_SYNC       (V_SYNC),
      .V_BACK       (V_BACK)
   ) u_timing (
      .vga_clk   (vga_clk),
      .vga_reset (vga_reset),
      .o_tim     (w_tim),
      .o_lane    (w_lane)
   );

   // The frame-start cycle already scans with the freshly latched enable.
   assign w_run = w_tim.origin ? enable : r_run;

   assign w_unused_alpha = ^{fifo.data_fifo_rd_data[127:120], fifo.data_fifo_rd_data[95:88],
                             fifo.data_fifo_rd_data[63:56],   fifo.data_fifo_rd_data[31:24]};

   always_comb begin
      w_grab  = 1'b0;
      w_miss  = 1'b0;
      w_drain = 1'b0;
      w_pix   = UNDERFLOW_RGB;
      if (!vga_reset && w_run) begin
         if (w_tim.active) begin
            if (w_lane == 2'd0) begin
               w_grab = !fifo.data_fifo_empty;
               w_miss = fifo.data_fifo_empty;
               if (!fifo.data_fifo_empty) w_pix = fifo.data_fifo_rd_data[RGB_W-1:0];
            end else if (r_word_ok) begin
               unique case (w_lane)
                  2'd1:    w_pix = r_pix[1];
                  2'd2:    w_pix = r_pix[2];
                  default: w_pix = r_pix[3];
               endcase
            end
         end else begin
            w_drain = (r_debt != '0) && !fifo.data_fifo_empty;
         end
      end
   end

   assign fifo.vga_rd_valid = w_grab | w_drain;

   always_ff @(posedge vga_clk) begin
      if (vga_reset) begin
         r_run       <= 1'b0;
         r_debt      <= '0;
         r_word_ok   <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_run <= w_run;
         if (w_tim.origin && !enable)       r_debt <= '0;
         else if (w_miss && r_debt != '1)   r_debt <= r_debt + 1'b1;
         else if (w_drain)                  r_debt <= r_debt - 1'b1;
         if (w_grab || w_miss) r_word_ok <= w_grab;
         if (w_miss)             r_underflow <= 1'b1;
         else if (underflow_clr) r_underflow <= 1'b0;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (w_grab) begin
         for (int k = 1; k < LANES; k++) r_pix[k] <= fifo.data_fifo_rd_data[LANE_W*k +: RGB_W];
      end
   end

   // Output register stage: sync, de and rgb leave together one cycle after the counters.
   always_ff @(posedge vga_clk) begin
      if (vga_reset) begin
         r_hsync_p1 <= ~SYNC_POL;
         r_vsync_p1 <= ~SYNC_POL;
         r_de_p1    <= 1'b0;
         r_rgb_p1   <= '0;
         r_fs_p1    <= 1'b0;
      end else begin
         r_hsync_p1 <= w_tim.hsync ? SYNC_POL : ~SYNC_POL;
         r_vsync_p1 <= w_tim.vsync ? SYNC_POL : ~SYNC_POL;
         r_de_p1    <= w_tim.active;
         r_rgb_p1   <= (w_tim.active && w_run) ? w_pix : '0;
         r_fs_p1    <= w_tim.origin && enable;
      end
   end

   assign vga_hsync   = r_hsync_p1;
   assign vga_vsync   = r_vsync_p1;
   assign vga_de      = r_de_p1;
   assign vga_r       = r_rgb_p1[R_LSB +: 8];
   assign vga_g       = r_rgb_p1[G_LSB +: 8];
   assign vga_b       = r_rgb_p1[B_LSB +: 8];
   assign frame_start = r_fs_p1;
   assign underflow   = r_underflow;
endmodule

// File: tb/tb_vga_pixel_out.sv
// Scoreboard bench for vga_pixel_out on a tiny 8x2 raster with a queue-backed FIFO.
module tb_vga_pixel_out;
   import vga_pkg::*;

   localparam int W  = 8;
   localparam int H  = 2;
   localparam int HF = 1, HS = 1, HB = 1;
   localparam int VF = 1, VS = 1, VB = 1;
   localparam int HT = W + HF + HS + HB;
   localparam int VT = H + VF + VS + VB;
   localparam bit POL = 1'b1;
   localparam logic [23:0] MAG = 24'hFF00FF;
   localparam int DEBT_MAX = (1 << $clog2(W * H / 4 + 1)) - 1;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        uf;
      logic [23:0] rgb;
   } exp_t;

   logic vga_clk = 1'b0;
   logic vga_reset, enable, underflow_clr;
   logic vga_hsync, vga_vsync, vga_de, frame_start, underflow;
   logic [7:0] vga_r, vga_g, vga_b;

   vga_pixel_out_if fifo();

   vga_pixel_out #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
      .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(POL), .UNDERFLOW_RGB(MAG)
   ) dut (
      .vga_clk       (vga_clk),
      .vga_reset     (vga_reset),
      .enable        (enable),
      .fifo          (fifo),
      .vga_hsync     (vga_hsync),
      .vga_vsync     (vga_vsync),
      .vga_de        (vga_de),
      .vga_r         (vga_r),
      .vga_g         (vga_g),
      .vga_b         (vga_b),
      .frame_start   (frame_start),
      .underflow     (underflow),
      .underflow_clr (underflow_clr)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0;
   int errors = 0;

   exp_t         exp_q[$];
   logic [127:0] fifo_q[$];

   // Reference state: raster position since reset, latched run, missed-word debt.
   int           t = 0;
   bit           m_run = 0;
   int           m_debt = 0;
   bit           m_uf = 0;
   bit           m_ok = 0;
   logic [127:0] m_word = '0;

   exp_t mon_e;
   exp_t mon_got;

   always @(posedge vga_clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e   = exp_q.pop_front();
         mon_got = {vga_de, vga_hsync, vga_vsync, frame_start, underflow, vga_r, vga_g, vga_b};
         checks++;
         if (mon_got !== mon_e) begin
            errors++;
            $display("FAIL outputs @%0t: got de=%b hs=%b vs=%b fs=%b uf=%b rgb=%h, want de=%b hs=%b vs=%b fs=%b uf=%b rgb=%h",
                     $time, mon_got.de, mon_got.hs, mon_got.vs, mon_got.fs, mon_got.uf, mon_got.rgb,
                     mon_e.de, mon_e.hs, mon_e.vs, mon_e.fs, mon_e.uf, mon_e.rgb);
         end
      end
   end

   task automatic cycle(input bit rst, input bit en, input bit frc, input bit clr, input int fill);
      int          x, y;
      bit          act, run_eff, emp, pop, set;
      logic [23:0] pix;
      exp_t        e;
      @(negedge vga_clk);
      if (fifo_q.size() < 4 && $urandom_range(0, 99) < fill)
         fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
      emp = frc || (fifo_q.size() == 0);
      vga_reset     = rst;
      enable        = en;
      underflow_clr = clr;
      fifo.data_fifo_empty   = emp;
      fifo.data_fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : {$urandom, $urandom, $urandom, $urandom};
      #1;
      pop = 0; set = 0; pix = '0;
      if (rst) begin
         e = '{de: 1'b0, hs: !POL, vs: !POL, fs: 1'b0, uf: 1'b0, rgb: 24'h0};
         t = 0; m_run = 0; m_debt = 0; m_uf = 0; m_ok = 0;
      end else begin
         x = t % HT;
         y = (t / HT) % VT;
         act = (x < W) && (y < H);
         run_eff = (x == 0 && y == 0) ? en : m_run;
         if (act && run_eff) begin
            if (x % 4 == 0) begin
               m_ok = !emp;
               if (!emp) begin
                  pop = 1;
                  m_word = fifo_q[0];
               end else begin
                  set = 1;
                  if (m_debt < DEBT_MAX) m_debt++;
               end
            end
            pix = m_ok ? 24'(m_word >> (32 * (x % 4))) : MAG;
         end else if (!act && run_eff && m_debt > 0 && !emp) begin
            pop = 1;
            m_debt--;
         end
         if (x == 0 && y == 0 && !en) m_debt = 0;
         m_run = run_eff;
         m_uf  = set ? 1'b1 : (clr ? 1'b0 : m_uf);
         e.de  = act;
         e.hs  = (x >= W + HF && x < W + HF + HS) ? POL : !POL;
         e.vs  = (y >= H + VF && y < H + VF + VS) ? POL : !POL;
         e.fs  = (x == 0 && y == 0 && en);
         e.uf  = m_uf;
         e.rgb = (act && run_eff) ? pix : 24'h0;
         t++;
      end
      exp_q.push_back(e);
      checks++;
      if (fifo.vga_rd_valid !== pop) begin
         errors++;
         $display("FAIL pop @%0t: rd_valid=%b, want %b (empty=%b)", $time, fifo.vga_rd_valid, pop, emp);
      end
      if (fifo.vga_rd_valid === 1'b1 && !emp && fifo_q.size() > 0) void'(fifo_q.pop_front());
   endtask

   task automatic go_to(input int gx, input int gy, input bit en);
      int n = 0;
      while (!((t % HT) == gx && ((t / HT) % VT) == gy) && n < 2 * HT * VT) begin
         cycle(0, en, 0, 0, 100);
         n++;
      end
   endtask

   bit en_r;

   initial begin
      vga_reset = 1'b1; enable = 1'b0; underflow_clr = 1'b0;
      fifo.data_fifo_empty = 1'b1; fifo.data_fifo_rd_data = '0;
      repeat (3) cycle(1, 0, 0, 0, 100);

      // Disabled, then enabled mid-frame: nothing scans out until the next origin.
      repeat (20) cycle(0, 0, 0, 0, 100);
      repeat (2 * HT * VT) cycle(0, 1, 0, 0, 100);

      // Second word of line 0 missing, then repaid in the following hblank.
      go_to(4, 0, 1);
      cycle(0, 1, 1, 0, 100);
      repeat (HT * VT) cycle(0, 1, 0, 0, 100);

      // Clear alone, then clear colliding with a fresh miss.
      repeat (3) cycle(0, 1, 0, 1, 100);
      go_to(4, 0, 1);
      cycle(0, 1, 1, 1, 100);
      repeat (HT * VT) cycle(0, 1, 0, 0, 100);

      en_r = 1'b1;
      for (int i = 0; i < 30 * HT * VT; i++) begin
         if ($urandom_range(0, 99) == 0) en_r = !en_r;
         cycle(0, en_r, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 60);
      end

      // Reset mid-line with debt outstanding; the debt must not survive.
      go_to(0, 0, 1);
      go_to(0, 1, 1);
      cycle(0, 1, 1, 0, 100);
      go_to(5, 1, 1);
      cycle(1, 1, 0, 0, 100);
      repeat (2 * HT * VT) cycle(0, 1, 0, 0, 100);

      repeat (3) @(negedge vga_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected outputs never observed, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
